// File: rtl/disp_frame_rx.sv
// +----------------------------------------------------------------------------+
// | disp_frame_rx : serial frame receiver driving the four-digit Display latch |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module disp_frame_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PRIEM_CYCLES = 10
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       rxd,
  output logic [7:0] inp,
  output logic       priem,
  output logic       SET1,
  output logic       SET2,
  output logic       SET3,
  output logic       SET4,
  output logic       busy,
  output logic       err
);

  localparam int c_cmax = (CLKS_PER_BIT > PRIEM_CYCLES) ? CLKS_PER_BIT : PRIEM_CYCLES;
  localparam int c_cw   = $clog2(c_cmax + 1);
  localparam logic [c_cw-1:0] c_bit   = c_cw'(CLKS_PER_BIT);
  localparam logic [c_cw-1:0] c_half  = c_cw'(CLKS_PER_BIT / 2);
  localparam logic [c_cw-1:0] c_priem = c_cw'(PRIEM_CYCLES);
  localparam logic [c_cw-1:0] c_one   = c_cw'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_ADDR    = 3'd2,
    S_DATA    = 3'd3,
    S_PARITY  = 3'd4,
    S_STOP    = 3'd5,
    S_PRESENT = 3'd6,
    S_WAITHI  = 3'd7
  } t_state;

  t_state            r_state;
  t_state            w_next;
  logic [1:0]        r_sync;
  logic [1:0]        r_vld;
  logic              r_hi;
  logic [c_cw-1:0]   r_cnt;
  logic [3:0]        r_bitn;
  logic [10:0]       r_shift;
  logic [7:0]        r_inp;
  logic              r_priem;
  logic [3:0]        r_set;
  logic              r_err;

  logic              w_rs;
  logic              w_valid;
  logic              w_tick;
  logic              w_par;
  logic              w_cnt_clr;
  logic              w_bit_clr;
  logic              w_shift;
  logic              w_good;
  logic              w_bad;
  logic              w_pres_end;

  assign w_rs    = r_sync[1];
  // r_vld marks when the synchroniser holds real line samples rather than reset ones
  assign w_valid = r_vld[1];
  assign w_tick  = (r_cnt == c_bit);
  assign w_par   = ^r_shift;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_bit_clr  = 1'b0;
    w_shift    = 1'b0;
    w_good     = 1'b0;
    w_bad      = 1'b0;
    w_pres_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        // Only a genuine high-to-low transition starts a frame; a line already low waits it out
        if (w_valid && !w_rs) begin
          w_next = r_hi ? S_START : S_WAITHI;
        end
      end
      S_START: begin
        if (r_cnt == c_half) begin
          w_cnt_clr = 1'b1;
          w_bit_clr = 1'b1;
          w_next    = w_rs ? S_IDLE : S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_tick) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_bitn == 4'd2) w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_bitn == 4'd10) w_next = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          w_next    = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_cnt_clr = 1'b1;
          if (!w_rs) begin
            w_bad  = 1'b1;
            w_next = S_WAITHI;
          end else if (w_par) begin
            w_bad  = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_good = 1'b1;
            w_next = S_PRESENT;
          end
        end
      end
      S_PRESENT: begin
        if (r_cnt == c_priem) begin
          w_pres_end = 1'b1;
          w_next     = S_IDLE;
        end
      end
      S_WAITHI: begin
        if (w_valid && w_rs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_sync  <= 2'b11;
      r_vld   <= 2'b00;
      r_hi    <= 1'b0;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_inp   <= '0;
      r_priem <= 1'b0;
      r_set   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rxd};
      r_vld  <= {r_vld[0], 1'b1};
      r_hi   <= w_valid & w_rs;
      r_err  <= w_bad;

      if (w_cnt_clr) begin
        r_cnt <= c_one;
      end else if (r_state != S_WAITHI) begin
        r_cnt <= r_cnt + c_one;
      end

      if (w_bit_clr) begin
        r_bitn <= 4'd1;
      end else if (w_shift) begin
        r_bitn <= r_bitn + 4'd1;
      end

      // LSB-first: after 11 shifts, [1:0]=addr, [9:2]=data, [10]=parity
      if (w_shift) r_shift <= {w_rs, r_shift[10:1]};

      if (w_good) begin
        r_inp   <= r_shift[9:2];
        r_priem <= 1'b1;
        r_set   <= 4'b0001 << r_shift[1:0];
      end else if (w_pres_end) begin
        r_priem <= 1'b0;
        r_set   <= '0;
      end
    end
  end

  assign inp   = r_inp;
  assign priem = r_priem;
  assign SET1  = r_set[0];
  assign SET2  = r_set[1];
  assign SET3  = r_set[2];
  assign SET4  = r_set[3];
  assign busy  = (r_state != S_IDLE);
  assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_disp_frame_rx.sv
// +----------------------------------------------------------------------------+
// | tb_disp_frame_rx : directed self-checking bench for disp_frame_rx          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_disp_frame_rx;

  localparam int CPB = 4;
  localparam int PC  = 10;

  logic       clk = 1'b0;
  logic       Reset;
  logic       rxd;
  logic [7:0] inp;
  logic       priem;
  logic       SET1, SET2, SET3, SET4;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  disp_frame_rx #(
    .CLKS_PER_BIT (CPB),
    .PRIEM_CYCLES (PC)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .rxd   (rxd),
    .inp   (inp),
    .priem (priem),
    .SET1  (SET1),
    .SET2  (SET2),
    .SET3  (SET3),
    .SET4  (SET4),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bits change 1 time unit after an edge; returns 1 unit after the last edge of the last bit
  task automatic send_frame(input logic [1:0] a, input logic [7:0] d, input logic flip,
                            input logic stopv, input int nbits);
    logic [12:0] bits;
    logic        par;
    par  = (^{d, a}) ^ flip;
    bits = {stopv, par, d, a, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rxd = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_good(input logic [1:0] a, input logic [7:0] d);
    int         hi;
    logic       set_ok;
    logic [3:0] sel;
    sel = 4'b0001 << a;
    send_frame(a, d, 1'b0, 1'b1, 13);
    check("priem_before_t0_51", 32'(priem), 32'd0);
    @(posedge clk); #1;
    check("priem_rise", 32'(priem), 32'd1);
    check("set_select", 32'({SET4, SET3, SET2, SET1}), 32'(sel));
    check("inp_value", 32'(inp), 32'(d));
    check("err_on_good", 32'(err), 32'd0);
    hi     = 0;
    set_ok = 1'b1;
    repeat (15) begin
      if (priem) begin
        hi++;
        if ({SET4, SET3, SET2, SET1} != sel) set_ok = 1'b0;
      end else if ({SET4, SET3, SET2, SET1} != 4'b0000) begin
        set_ok = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("priem_len", 32'(hi), 32'(PC));
    check("set_window", 32'(set_ok), 32'd1);
    check("inp_hold", 32'(inp), 32'(d));
    check("busy_idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int bcnt;
    int bad;
    int busy_low;

    Reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({inp, priem, SET4, SET3, SET2, SET1, busy, err}), 32'd0);
    Reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_after_release", 32'({priem, busy, err}), 32'd0);

    // Test 1 and 2: good frames on every digit
    expect_good(2'd0, 8'd46);
    expect_good(2'd1, 8'hA5);
    expect_good(2'd2, 8'h00);
    expect_good(2'd3, 8'hFF);

    // Test 3: flipped parity
    send_frame(2'd1, 8'h3C, 1'b1, 1'b1, 13);
    check("perr_err_before", 32'(err), 32'd0);
    @(posedge clk); #1;
    check("perr_err_pulse", 32'(err), 32'd1);
    check("perr_priem", 32'(priem), 32'd0);
    @(posedge clk); #1;
    check("perr_err_one_cycle", 32'(err), 32'd0);
    check("perr_inp_kept", 32'(inp), 32'hFF);
    check("perr_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;

    // Test 4: stop bit 0 then line held low
    send_frame(2'd2, 8'h12, 1'b0, 1'b0, 13);
    @(posedge clk); #1;
    check("serr_err_pulse", 32'(err), 32'd1);
    busy_low = 0;
    bad      = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (!busy) busy_low++;
      if (priem || err) bad++;
    end
    check("serr_busy_held", 32'(busy_low), 32'd0);
    check("serr_no_activity", 32'(bad), 32'd0);
    rxd = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("serr_busy_release", 32'(busy), 32'd0);
    check("serr_inp_kept", 32'(inp), 32'hFF);

    // Test 5: one-cycle glitch on the idle line
    rxd = 1'b0;
    @(posedge clk); #1;
    rxd  = 1'b1;
    bcnt = 0;
    bad  = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (priem || err) bad++;
    end
    check("glitch_busy_cycles", 32'(bcnt), 32'd2);
    check("glitch_no_err_priem", 32'(bad), 32'd0);
    check("glitch_idle", 32'(busy), 32'd0);

    // Test 6: reset during data bit 5
    send_frame(2'd3, 8'h5A, 1'b0, 1'b1, 9);
    check("midframe_busy", 32'(busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'({inp, priem, SET4, SET3, SET2, SET1, busy, err}), 32'd0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    Reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_idle", 32'(busy), 32'd0);
    expect_good(2'd2, 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
